alu_arbiter: RTL and testbench

Shares the single combinational 32-bit ALU between two requesters, such as the execute stage and the branch/compare unit. It performs round-robin arbitration, registers the winning operation onto the ALU inputs for one execute cycle and captures the ALU outputs. It returns the result to the granted requester over a valid/ready response channel. The block sits between the requesters and the ALU instance, and owns every ALU input.

---
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_arbiter.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational 32-bit ALU between two requesters.
// A request is granted in IDLE (round-robin or fixed priority), its fields
// are registered onto the ALU inputs for one EXEC cycle, the ALU outputs are
// captured at the end of EXEC, and the result is offered in RESP until the
// response channel consumes it.
//
// Handshake semantics (both request channels and the response channel):
//   a transfer happens on a rising edge where valid and ready are both 1.
//   The requester holds valid and its fields stable until that edge; ready
//   never depends on anything but state, last grant and the two valids.
//   rsp_* stay stable while rsp_valid = 1 and rsp_ready = 0.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid/ready             request handshake for requester N (0/1)
//   reqN_ctrl/src/a/b/imm        opcode, operand-2 select, operands
//   rsp_valid/ready              response handshake
//   rsp_id                       requester that owns the response
//   rsp_result/zero/overflow     captured ALU outputs (0 when illegal)
//   rsp_illegal                  opcode 11..15, operation not executed
//   alu_src/data1/data2/imm/ctrl registered ALU inputs
//   alu_result/zero/overflow     ALU outputs
module alu_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_ctrl,
  input  logic        req0_src,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req0_imm,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_ctrl,
  input  logic        req1_src,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [31:0] req1_imm,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        rsp_illegal,

  output logic        alu_src,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [31:0] alu_imm,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAST_LEGAL_OP = 4'd10;

  state_t state_q;
  state_t state_d;
  logic   last_grant_q;
  logic   grant;
  logic   accept;

  // Winner among the current valids. Only meaningful in IDLE; the ready
  // outputs gate it with the state.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      grant = 1'b1;
    end else if (req0_valid && req1_valid) begin
      grant = (RR_EN != 0) ? ~last_grant_q : 1'b0;
    end
  end

  assign req0_ready = (state_q == IDLE) && !grant && req0_valid;
  assign req1_ready = (state_q == IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;
  assign rsp_valid  = (state_q == RESP);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand registers, grant history and response capture.
  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rsp_id       <= 1'b0;
      rsp_result   <= 32'd0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_illegal  <= 1'b0;
      alu_src      <= 1'b0;
      alu_data1    <= 32'd0;
      alu_data2    <= 32'd0;
      alu_imm      <= 32'd0;
      alu_ctrl     <= 4'd0;
    end else begin
      if (accept) begin
        alu_ctrl     <= grant ? req1_ctrl : req0_ctrl;
        alu_src      <= grant ? req1_src  : req0_src;
        alu_data1    <= grant ? req1_a    : req0_a;
        alu_data2    <= grant ? req1_b    : req0_b;
        alu_imm      <= grant ? req1_imm  : req0_imm;
        last_grant_q <= grant;
        rsp_id       <= grant;
      end
      // Whatever the ALU produces for an undefined opcode is discarded.
      if (state_q == EXEC) begin
        if (alu_ctrl > LAST_LEGAL_OP) begin
          rsp_result   <= 32'd0;
          rsp_zero     <= 1'b0;
          rsp_overflow <= 1'b0;
          rsp_illegal  <= 1'b1;
        end else begin
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_overflow;
          rsp_illegal  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Bench for alu_arbiter. Two instances share the request inputs: dut
// (round-robin) and dut_fp (fixed priority, response always consumed).
// Each instance is closed by a behavioural ALU model. Expected responses
// come from a reference function evaluated on the request fields at accept.
module tb_alu_arbiter;

  localparam int W = 36; // {id, illegal, overflow, zero, result}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req0_valid, req1_valid;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        req0_src, req1_src;
  logic [31:0] req0_a, req0_b, req0_imm, req1_a, req1_b, req1_imm;
  logic        rsp_ready;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_overflow, rsp_illegal;
  logic        alu_src;
  logic [31:0] alu_data1, alu_data2, alu_imm, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_overflow;

  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
  logic [31:0] fp_rsp_result;
  logic        fp_rsp_zero, fp_rsp_overflow, fp_rsp_illegal;
  logic        fp_alu_src;
  logic [31:0] fp_alu_data1, fp_alu_data2, fp_alu_imm, fp_alu_result;
  logic [3:0]  fp_alu_ctrl;
  logic        fp_alu_zero, fp_alu_overflow;

  int checks = 0;
  int failures = 0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  bit           mon_en = 1'b0;

  // Behavioural ALU: returns {overflow, zero, result}. Undefined opcodes
  // deliberately produce junk so masking in the arbiter is observable.
  function automatic logic [33:0] alu_fn(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic        v;
    r = 32'd0;
    v = 1'b0;
    case (c)
      4'd0:  begin r = x + y; v = (x[31] == y[31]) && (r[31] != x[31]); end
      4'd1:  r = x + y;
      4'd2:  begin r = x - y; v = (x[31] != y[31]) && (r[31] != x[31]); end
      4'd3:  r = x - y;
      4'd4:  r = x & y;
      4'd5:  r = x | y;
      4'd6:  r = x << y[4:0];
      4'd7:  r = x >> y[4:0];
      4'd8:  r = {31'd0, $signed(x) < $signed(y)};
      4'd9:  r = {31'd0, x == y};
      4'd10: r = {31'd0, x != y};
      default: begin r = 32'hBAD0_BAD0; v = 1'b1; end
    endcase
    return {v, (c > 4'd10) ? 1'b1 : (r == 32'd0), r};
  endfunction

  // Reference response for a request as it looked when accepted.
  function automatic logic [W-1:0] ref_rsp(input logic id, input logic [3:0] c, input logic s,
                                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    if (c > 4'd10) return {id, 1'b1, 34'd0};
    return {id, 1'b0, alu_fn(c, a, s ? imm : b)};
  endfunction

  logic [33:0] alu_out, fp_alu_out;
  always_comb alu_out    = alu_fn(alu_ctrl, alu_data1, alu_src ? alu_imm : alu_data2);
  always_comb fp_alu_out = alu_fn(fp_alu_ctrl, fp_alu_data1, fp_alu_src ? fp_alu_imm : fp_alu_data2);
  assign {alu_overflow, alu_zero, alu_result}          = alu_out;
  assign {fp_alu_overflow, fp_alu_zero, fp_alu_result} = fp_alu_out;

  alu_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl), .req0_src(req0_src),
    .req0_a(req0_a), .req0_b(req0_b), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl), .req1_src(req1_src),
    .req1_a(req1_a), .req1_b(req1_b), .req1_imm(req1_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal),
    .alu_src(alu_src), .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_imm(alu_imm),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  alu_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_ctrl(req0_ctrl), .req0_src(req0_src),
    .req0_a(req0_a), .req0_b(req0_b), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_ctrl(req1_ctrl), .req1_src(req1_src),
    .req1_a(req1_a), .req1_b(req1_b), .req1_imm(req1_imm),
    .rsp_valid(fp_rsp_valid), .rsp_ready(1'b1), .rsp_id(fp_rsp_id), .rsp_result(fp_rsp_result),
    .rsp_zero(fp_rsp_zero), .rsp_overflow(fp_rsp_overflow), .rsp_illegal(fp_rsp_illegal),
    .alu_src(fp_alu_src), .alu_data1(fp_alu_data1), .alu_data2(fp_alu_data2), .alu_imm(fp_alu_imm),
    .alu_ctrl(fp_alu_ctrl), .alu_result(fp_alu_result), .alu_zero(fp_alu_zero), .alu_overflow(fp_alu_overflow)
  );

  // Monitor: on every accept push the reference response, on every
  // response handshake push what the DUT presented.
  always @(negedge clk) begin
    #1;
    if (mon_en && !rst) begin
      if (req0_ready) exp_q.push_back(ref_rsp(1'b0, req0_ctrl, req0_src, req0_a, req0_b, req0_imm));
      else if (req1_ready) exp_q.push_back(ref_rsp(1'b1, req1_ctrl, req1_src, req1_a, req1_b, req1_imm));
      if (rsp_valid && rsp_ready)
        obs_q.push_back({rsp_id, rsp_illegal, rsp_overflow, rsp_zero, rsp_result});
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic set_req(input int n, input logic [3:0] c, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    if (n == 0) begin
      req0_ctrl = c; req0_src = s; req0_a = a; req0_b = b; req0_imm = imm;
    end else begin
      req1_ctrl = c; req1_src = s; req1_a = a; req1_b = b; req1_imm = imm;
    end
  endtask

  // Raise valid, wait (bounded) for ready, drop valid after the accept edge.
  task automatic issue(input int n, input logic [3:0] c, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       output int acc_cyc, output bit ok);
    set_req(n, c, s, a, b, imm);
    if (n == 0) req0_valid = 1'b1; else req1_valid = 1'b1;
    ok = 1'b0;
    acc_cyc = -1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if ((n == 0) ? req0_ready : req1_ready) begin
        acc_cyc = cyc;
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; returns the presented response.
  task automatic wait_rsp(output logic [W-1:0] got, output int rsp_cyc, output bit ok);
    ok = 1'b0;
    got = '0;
    rsp_cyc = -1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (rsp_valid) begin
        got = {rsp_id, rsp_illegal, rsp_overflow, rsp_zero, rsp_result};
        rsp_cyc = cyc;
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
    end
    checks++;
    if ({rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_illegal} !== 36'd0) begin
      failures++; $display("FAIL reset_rsp_fields got=%h exp=0", {rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_illegal});
    end
    checks++;
    if ({alu_src, alu_data1, alu_data2, alu_imm, alu_ctrl} !== 101'd0) begin
      failures++; $display("FAIL reset_alu_inputs got=%h exp=0", {alu_src, alu_data1, alu_data2, alu_imm, alu_ctrl});
    end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(0, 4'd0, 1'b0, 32'd7, 32'd5, 32'h55);
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL single_accept ready got=%b exp=10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({alu_ctrl, alu_src, alu_data1, alu_data2, rsp_valid} !== {4'd0, 1'b0, 32'd7, 32'd5, 1'b0}) begin
      failures++; $display("FAIL single_exec ctrl=%0d src=%b d1=%0d d2=%0d rsp_valid=%b exp 0 0 7 5 0",
                           alu_ctrl, alu_src, alu_data1, alu_data2, rsp_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_illegal, rsp_overflow, rsp_zero, rsp_result} !== {5'b10000, 32'd12}) begin
      failures++; $display("FAIL single_rsp valid=%b id=%b ill=%b ovf=%b zero=%b result=%0d exp 1 0 0 0 0 12",
                           rsp_valid, rsp_id, rsp_illegal, rsp_overflow, rsp_zero, rsp_result);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL single_consumed rsp_valid got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_rr_tie();
    int ids[4];
    int cycs[4];
    int n_acc = 0;
    int both = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 4'd0, 1'b0, 32'd10, 32'd20, 32'd0);
    set_req(1, 4'd2, 1'b0, 32'd50, 32'd8, 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      #1;
      if (req0_ready && req1_ready) both++;
      if ((req0_ready || req1_ready) && n_acc < 4) begin
        ids[n_acc] = req1_ready ? 1 : 0;
        cycs[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (n_acc != 4 || both != 0) begin
      failures++; $display("FAIL rr_count accepts=%0d double_ready=%0d exp 4 0", n_acc, both);
    end
    for (int i = 0; i < n_acc; i++) begin
      checks++;
      if (ids[i] != i % 2) begin
        failures++; $display("FAIL rr_order grant%0d got=%0d exp=%0d", i, ids[i], i % 2);
      end
      if (i > 0) begin
        checks++;
        if (cycs[i] - cycs[i-1] != 3) begin
          failures++; $display("FAIL rr_spacing grant%0d gap got=%0d exp=3", i, cycs[i] - cycs[i-1]);
        end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    int g0 = 0;
    int g1 = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 4'd4, 1'b0, 32'hFF00, 32'h0FF0, 32'd0);
    set_req(1, 4'd5, 1'b0, 32'h1, 32'h2, 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      #1;
      if (fp_req0_ready) g0++;
      if (fp_req1_ready) g1++;
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (g0 != 5 || g1 != 0) begin
      failures++; $display("FAIL fixed_priority grants0=%0d grants1=%0d exp 5 0", g0, g1);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_imm_branch();
    int acc, rc;
    bit ok, ok2;
    logic [W-1:0] got;
    @(negedge clk);
    rsp_ready = 1'b1;
    issue(1, 4'd2, 1'b1, 32'd3, 32'd100, 32'd3, acc, ok);
    wait_rsp(got, rc, ok2);
    checks++;
    if (!ok || !ok2 || rc != acc + 2 || got !== {4'b1001, 32'd0}) begin
      failures++; $display("FAIL imm_sub ok=%b/%b latency=%0d rsp=%h exp latency 2 rsp=%h",
                           ok, ok2, rc - acc, got, {4'b1001, 32'd0});
    end
    issue(1, 4'd10, 1'b0, 32'd4, 32'd9, 32'd0, acc, ok);
    wait_rsp(got, rc, ok2);
    checks++;
    if (!ok || !ok2 || got !== {4'b1000, 32'd1}) begin
      failures++; $display("FAIL branch_bne ok=%b/%b rsp=%h exp=%h", ok, ok2, got, {4'b1000, 32'd1});
    end
  endtask

  task automatic test_backpressure_illegal();
    int acc, rc;
    bit ok, ok2;
    logic [W-1:0] got;
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(0, 4'd12, 1'b0, $urandom, $urandom, $urandom, acc, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL bp_accept no accept within bound");
    end
    // Now in EXEC; both requesters wait behind the stalled response.
    set_req(1, 4'd5, 1'b0, 32'hF0, 32'h0F, 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_illegal, rsp_overflow, rsp_zero, rsp_result} !== {5'b10100, 32'd0}) begin
        failures++; $display("FAIL bp_hold cycle%0d valid=%b id=%b ill=%b ovf=%b zero=%b result=%h exp 1 0 1 0 0 0",
                             k, rsp_valid, rsp_id, rsp_illegal, rsp_overflow, rsp_zero, rsp_result);
      end
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        failures++; $display("FAIL bp_ready cycle%0d got=%b exp=00", k, {req0_ready, req1_ready});
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
      failures++; $display("FAIL bp_release valid/ready0/ready1 got=%b exp=001", {rsp_valid, req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(got, rc, ok2);
    checks++;
    if (!ok2 || got !== {4'b1000, 32'hFF}) begin
      failures++; $display("FAIL bp_next_rsp ok=%b rsp=%h exp=%h", ok2, got, {4'b1000, 32'hFF});
    end
  endtask

  task automatic test_reset_exec();
    int acc, rc;
    bit ok, ok2;
    int seen = 0;
    logic [W-1:0] got;
    @(negedge clk);
    rsp_ready = 1'b1;
    issue(0, 4'd0, 1'b1, 32'h1234, 32'h1, 32'h77, acc, ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (!ok || rsp_valid !== 1'b0 || {alu_src, alu_data1, alu_data2, alu_imm, alu_ctrl} !== 101'd0) begin
      failures++; $display("FAIL rst_exec ok=%b rsp_valid=%b alu=%h exp 1 0 0", ok, rsp_valid,
                           {alu_src, alu_data1, alu_data2, alu_imm, alu_ctrl});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL rst_no_rsp rsp_valid cycles got=%0d exp=0", seen);
    end
    @(negedge clk);
    set_req(0, 4'd0, 1'b0, 32'd1, 32'd2, 32'd0);
    set_req(1, 4'd1, 1'b0, 32'd5, 32'd6, 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL rst_tie ready got=%b exp=10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(got, rc, ok2);
    checks++;
    if (!ok2 || got !== {4'b0000, 32'd3}) begin
      failures++; $display("FAIL rst_tie_rsp ok=%b rsp=%h exp=%h", ok2, got, {4'b0000, 32'd3});
    end
  endtask

  task automatic test_random();
    bit acc0 = 1'b0;
    bit acc1 = 1'b0;
    int n;
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    mon_en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (acc0) begin
        req0_valid = 1'b0; acc0 = 1'b0;
      end else if (!req0_valid && $urandom_range(0, 1) == 1) begin
        set_req(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
        req0_valid = 1'b1;
      end
      if (acc1) begin
        req1_valid = 1'b0; acc1 = 1'b0;
      end else if (!req1_valid && $urandom_range(0, 1) == 1) begin
        set_req(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
        req1_valid = 1'b1;
      end
      #1;
      acc0 = req0_ready;
      acc1 = req1_ready;
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != obs_q.size() || exp_q.size() < 20) begin
      failures++; $display("FAIL random_count responses got=%0d exp=%0d (need >=20)", obs_q.size(), exp_q.size());
    end
    n = (exp_q.size() < obs_q.size()) ? exp_q.size() : obs_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL random_rsp%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    set_req(0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    set_req(1, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    test_reset();
    test_single();
    test_rr_tie();
    test_fixed_priority();
    test_imm_branch();
    test_backpressure_illegal();
    test_reset_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
